// File: rtl/decoder_pkg.sv
// Purpose: shared types and the combinational decode function for decoder_pipelined.
// Latency: none; this file holds only types and a pure function.
// Backpressure: not applicable.
// Contents: dec_mode_t (decode mode select) and decode_word(code, mode, ena, acc).
package decoder_pkg;

  // Widest word the decoder supports (N = 8). Callers cast the result down to their width.
  localparam int DEC_MAX_W = 256;

  typedef enum logic [1:0] {
    DEC_ONEHOT = 2'd0,
    DEC_THERMO = 2'd1,
    DEC_ACCUM  = 2'd2,
    DEC_RSVD   = 2'd3
  } dec_mode_t;

  // acc must already be the post-clear accumulator value (acc_next).
  // The function returns the full DEC_MAX_W-bit word. Only the low 2**N bits are meaningful.
  function automatic logic [DEC_MAX_W-1:0] decode_word(
    input logic [7:0]           code,
    input dec_mode_t            mode,
    input logic                 ena,
    input logic [DEC_MAX_W-1:0] acc
  );
    logic [DEC_MAX_W-1:0] w;
    w = '0;
    if (ena) begin
      case (mode)
        DEC_ONEHOT: begin
          for (int i = 0; i < DEC_MAX_W; i++) w[i] = (i == int'(code));
        end
        DEC_THERMO: begin
          for (int i = 0; i < DEC_MAX_W; i++) w[i] = (i <= int'(code));
        end
        DEC_ACCUM: begin
          w       = acc;
          w[code] = 1'b1;
        end
        default: w = '0;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/dec_skid_stage.sv
// Purpose: generic W-bit valid/ready output register with a one-entry skid buffer.
// Latency: 1 cycle from accept to out_valid. Throughput is 1 beat per cycle while out_ready is high.
// Backpressure: a beat accepted during a stall parks in the skid, and in_ready drops until the skid drains.
// Ports: clk/rst (sync, active high); in_valid/in_ready/in_data upstream; out_valid/out_ready/out_data downstream.
module dec_skid_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         load_out;

  assign in_ready = ~skid_valid & ~rst;
  assign accept   = in_valid & in_ready;
  // The output register may take new data when it is empty or its beat is leaving.
  assign load_out = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (load_out) begin
      if (skid_valid) begin
        // The skid holds the older beat, so it drains first. in_ready is low here, so nothing is accepted.
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      // Stalled with a valid output: park the new beat. out_data stays bit-stable.
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/decoder_pipelined.sv
// Purpose: N-to-2^N decoder (one-hot / thermometer / accumulate) with a registered valid/ready output.
// Latency: 1 cycle from accept to out_valid. Throughput is 1 beat per cycle while out_ready is high.
// Backpressure: a one-entry skid absorbs one beat during a stall, and in_ready falls while the skid is full.
// Ports: clk, rst (sync, active high); ena, in_valid/in_ready, in[N-1:0], mode[1:0], clear;
//        out_valid/out_ready, out[OUT_W-1:0].
module decoder_pipelined
  import decoder_pkg::*;
#(
  parameter  int N     = 5,
  localparam int OUT_W = 2**N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out
);

  dec_mode_t        mode_e;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_next;
  logic [OUT_W-1:0] dec_word;
  logic             accept;

  assign mode_e   = dec_mode_t'(mode);
  assign accept   = in_valid & in_ready;
  assign acc_next = clear ? '0 : acc;
  assign dec_word = OUT_W'(decode_word(8'(in), mode_e, ena, DEC_MAX_W'(acc_next)));

  // In accumulate mode, dec_word already contains acc_next when ena=1 and is zero when ena=0.
  // ORing it with acc_next therefore covers both cases.
  // Any other cycle with clear high zeroes the accumulator. Output handshakes never touch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (accept && mode_e == DEC_ACCUM) begin
      acc <= acc_next | dec_word;
    end else if (clear) begin
      acc <= '0;
    end
  end

  dec_skid_stage #(
    .W(OUT_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out)
  );

endmodule

// File: tb/tb_decoder_pipelined.sv
module tb_decoder_pipelined;

  localparam int N     = 5;
  localparam int OUT_W = 32;

  logic             clk;
  logic             rst;
  logic             ena;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     code;
  logic [1:0]       mode;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] dout;

  decoder_pipelined dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (code),
    .mode     (mode),
    .clear    (clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned      n_cmp = 0;
  int unsigned      n_bad = 0;
  logic [31:0]      expq[$];
  logic [31:0]      acc_m;
  bit               stall_prev;
  logic [31:0]      prev_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference word, written from the decoding rules with plain arithmetic.
  function automatic logic [31:0] ref_word(input int c, input int md, input bit en,
                                           input logic [31:0] accn);
    logic [63:0] t;
    if (!en) return 32'd0;
    case (md)
      0: return 32'(64'd1 << c);
      1: begin
        t = (64'd2 << c) - 64'd1;
        return t[31:0];
      end
      2: return accn | 32'(64'd1 << c);
      default: return 32'd0;
    endcase
  endfunction

  // Call this on a negedge. It checks the visible state against the model, drives one cycle
  // of inputs, updates the model for the coming edge, and returns on the next negedge.
  task automatic step(input bit iv, input int c, input int md, input bit en,
                      input bit clr, input bit ordy);
    bit          acc_ok;
    bit          hs;
    logic [31:0] accn;
    logic [31:0] w;
    chk("out_valid", 64'(out_valid), 64'(expq.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(expq.size() < 2));
    if (expq.size() > 0) chk("out_data", 64'(dout), 64'(expq[0]));
    if (stall_prev) chk("stall_stable", 64'(dout), 64'(prev_out));
    in_valid  = iv;
    code      = N'(c);
    mode      = 2'(md);
    ena       = en;
    clear     = clr;
    out_ready = ordy;
    acc_ok     = iv && (expq.size() < 2);
    hs         = (expq.size() > 0) && ordy;
    stall_prev = (expq.size() > 0) && !ordy;
    prev_out   = dout;
    if (hs) void'(expq.pop_front());
    if (acc_ok) begin
      accn = clr ? 32'd0 : acc_m;
      w    = ref_word(c, md, en, accn);
      if (md == 2) acc_m = en ? w : accn;
      else if (clr) acc_m = 32'd0;
      expq.push_back(w);
    end else if (clr) begin
      acc_m = 32'd0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_low", 64'(in_ready), 64'd0);
    chk("rst_out_valid_low", 64'(out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    acc_m      = 32'd0;
    stall_prev = 1'b0;
    #1;
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_out", 64'(dout), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int  accepted;
    bit  iv;
    int  md;
    bit  clr;
    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; code = '0; mode = 2'd0;
    clear = 1'b0; out_ready = 1'b1;
    acc_m = 32'd0; stall_prev = 1'b0; prev_out = 32'd0;
    @(negedge clk);
    do_reset();
    @(negedge clk);

    // One-hot sweep, back to back.
    for (int i = 0; i < 32; i++) begin
      step(1, i, 0, 1, 0, 1);
      chk("onehot_valid", 64'(out_valid), 64'd1);
      chk("onehot_word", 64'(dout), 64'(32'd1 << i));
    end
    step(0, 0, 0, 1, 0, 1);

    // Thermometer and disabled beats.
    step(1, 0, 1, 1, 0, 1);  chk("thermo_0", 64'(dout), 64'h0000_0001);
    step(1, 4, 1, 1, 0, 1);  chk("thermo_4", 64'(dout), 64'h0000_001F);
    step(1, 31, 1, 1, 0, 1); chk("thermo_31", 64'(dout), 64'hFFFF_FFFF);
    step(1, 7, 1, 0, 0, 1);  chk("ena_off", 64'(dout), 64'h0);
    chk("ena_off_valid", 64'(out_valid), 64'd1);
    step(1, 7, 3, 1, 0, 1);  chk("mode3_zero", 64'(dout), 64'h0);

    // Accumulate with an in-beat clear, then a standalone clear.
    step(1, 3, 2, 1, 0, 1);  chk("accum_3", 64'(dout), 64'h08);
    step(1, 5, 2, 1, 0, 1);  chk("accum_5", 64'(dout), 64'h28);
    step(1, 3, 2, 1, 0, 1);  chk("accum_3b", 64'(dout), 64'h28);
    step(1, 1, 2, 1, 1, 1);  chk("accum_clr1", 64'(dout), 64'h02);
    step(0, 0, 0, 1, 1, 1);
    step(1, 0, 2, 1, 0, 1);  chk("accum_after_clr", 64'(dout), 64'h01);
    step(0, 0, 0, 1, 0, 1);

    // Back-pressure: the skid fills, in_ready falls, then the skid drains in order.
    step(1, 1, 0, 1, 0, 0);  chk("stall_first", 64'(dout), 64'h2);
    step(1, 2, 0, 1, 0, 0);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_hold", 64'(dout), 64'h2);
    step(1, 9, 0, 1, 0, 0);  chk("stall_hold2", 64'(dout), 64'h2);
    step(0, 0, 0, 1, 0, 1);  chk("skid_drain", 64'(dout), 64'h4);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);

    // Randomized traffic against the queue model.
    accepted = 0;
    for (int c = 0; c < 20000 && accepted < 1000; c++) begin
      iv  = ($urandom_range(0, 9) < 7);
      md  = $urandom_range(0, 3);
      clr = (md == 2 || !iv) ? ($urandom_range(0, 9) == 0) : 1'b0;
      if (iv && expq.size() < 2) accepted++;
      step(iv, $urandom_range(0, 31), md, ($urandom_range(0, 9) < 9), clr,
           ($urandom_range(0, 9) < 6));
    end
    for (int c = 0; c < 4; c++) step(0, 0, 0, 1, 0, 1);

    // Reset with two beats in flight and a non-zero accumulator.
    step(1, 9, 2, 1, 0, 0);
    step(1, 10, 2, 1, 0, 0);
    chk("midrst_full", 64'(in_ready), 64'd0);
    do_reset();
    step(1, 0, 2, 1, 0, 1);
    chk("midrst_acc_zero", 64'(dout), 64'h01);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_pipelined.md
Name: decoder_pipelined

Overview:
Parametrised N-to-2^N decoder with a registered, flow-controlled output stage. It replaces the purely combinational decoder tree where decoded words must cross a pipeline boundary, such as register-file write enables or bank selects. It adds runtime-selectable one-hot, thermometer and accumulate modes, plus a valid/ready handshake with a one-entry skid buffer for full throughput under back-pressure.

Parameters:
N, 5, input code width in bits (legal 1..8)
OUT_W, 2**N, output width; derived, never overridden

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
ena  input  1  decoder enable; 0 forces a zero decoded word (the beat still transfers)
in_valid  input  1  input beat valid
in_ready  output  1  block can accept an input beat
in  input  N  code to decode
mode  input  2  0 one-hot, 1 thermometer, 2 accumulate, 3 reserved
clear  input  1  synchronous clear of the accumulator
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the output beat
out  output  OUT_W  decoded word

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out=0, skid buffer empty, accumulator=0.
- in_ready = ~skid_valid & ~rst. It is 0 while rst is high and 1 on the first cycle after reset.
- Accept: a beat is accepted when in_valid & in_ready at a clk edge. ena, mode and clear are sampled with the beat.
- Decode, computed when a beat is accepted (ena=1):
  - mode 0: out[i] = (i == in).
  - mode 1: out[i] = (i <= in); in=0 gives 1, in=OUT_W-1 gives all ones.
  - mode 2: word = acc_next | onehot(in), where acc_next = clear ? 0 : acc. The accumulator loads the word.
  - mode 3: zero word; the accumulator is untouched.
- ena=0: zero word in every mode. In mode 2 the accumulator still takes acc_next (clear is honoured; no bit is ORed in).
- clear without an accepted beat: accumulator goes to 0 at the next edge. Output and skid registers are unaffected.
- The accumulator changes only on accept or clear, never on output handshakes.
- Latency: the beat accepted at edge k appears with out_valid=1 after edge k. Throughput is 1 beat/cycle while out_ready=1.
- Output register (out, out_valid) is loaded when it is empty or out_ready=1:
  - source is the skid entry if the skid is valid, else the accepted beat;
  - if neither exists, out_valid drops to 0.
- Skid: an accepted beat is written to the skid when out_valid=1 and out_ready=0. in_ready then falls on the next cycle. The skid drains into the output register on the first edge with out_ready=1.
- Stall stability: while out_valid=1 and out_ready=0, out is held bit-stable.
- Ordering is strictly FIFO. No beat is dropped or duplicated. At most 2 beats are in flight.
- Simultaneous output handshake and accept:
  - with the skid empty, the new beat goes directly to the output register;
  - with the skid full, in_ready=0, so no accept can occur.
- Reset mid-operation: all in-flight beats and the accumulator are discarded. No out_valid pulse appears on the cycle after reset.

Decomposition:
- Shared package decoder_pkg:
  - typedef enum logic [1:0] dec_mode_t {DEC_ONEHOT, DEC_THERMO, DEC_ACCUM, DEC_RSVD};
  - function decode_word(code, mode, ena, acc) returning the combinational word.
- One sub-module: dec_skid_stage, a generic OUT_W-wide valid/ready register plus skid entry, reusable elsewhere.
- The decode logic lives in decoder_pipelined.

Test Plan:
- Reset, then N=5, mode 0, ena=1, in=0..31 with out_ready=1 -> out=1<<in one cycle after each accept; 32 consecutive beats with no bubbles.
- mode 1, in=0, 4, 31 -> out=0x00000001, 0x0000001F, 0xFFFFFFFF; then ena=0, in=7 -> out=0.
- mode 2: in=3, 5, 3, then clear with in=1 on the same beat -> outs 0x08, 0x28, 0x28, 0x02; then clear alone -> next mode 2 in=0 gives 0x01.
- out_ready=0 while sending in=1 then 2 -> out holds 0x2 stable, in_ready=0 after the second accept; release out_ready -> 0x4 follows on the next cycle, nothing lost.
- Random in_valid/out_ready stalls over 1000 beats, checked against a scoreboard -> exact order and values, out stable during stalls.
- Assert rst with 2 beats in flight -> out_valid=0, out=0, in_ready=1 on the first cycle after reset; the accumulator reads 0 on the next mode 2 beat.
